// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// PipeStageSkid -- parametrised pipeline stage register with a 2-entry skid
// buffer, valid/ready handshake on both sides and a synchronous flush.
//
// A beat accepted while downstream is stalled is parked in the skid register.
// This lets in_ready come straight from a flop (~skid valid), so no
// combinational path runs from out_ready back to in_ready. Bubbles are shown
// as an all-zero payload (NOP) when ZERO_BUBBLE=1. When ZERO_BUBBLE=0 the
// last payload is held on out_data instead.
//
// Parameters:
//   PAYLOAD_W    payload width in bits
//   ZERO_BUBBLE  1: out_data forced to 0 while out_valid=0; 0: stale data held
//
// Ports:
//   clk        stage clock, rising edge
//   rst        asynchronous active-low reset (rst=0 resets)
//   flush      synchronous kill of all held beats, highest priority
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat (registered)
//   in_data    upstream payload
//   out_valid  beat presented downstream
//   out_ready  downstream accepts beat (0 = stall)
//   out_data   payload to downstream
//   occupancy  number of held beats, 0..2
//
// Optional feature, macro PIPE_STAGE_SKID_PERF_EN:
//   perf_stall_cnt   cycles with out_valid=1 and out_ready=0 (saturating)
//   perf_bubble_cnt  cycles with out_valid=0 and out_ready=1 (saturating)
//   Both counters are cleared by reset only, never by flush.
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int PAYLOAD_W   = 76,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_bubble_cnt
`endif
);

  // The state bits are the valid flags themselves: bit 1 = skid valid,
  // bit 0 = main valid. SKID_ONLY cannot be reached and is recovered from.
  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    ONE       = 2'b01,
    SKID_ONLY = 2'b10,
    FULL      = 2'b11
  } state_e;

  state_e                 state_q;
  logic [PAYLOAD_W-1:0]   mainData_q;
  logic [PAYLOAD_W-1:0]   skidData_q;

  logic                   mainValid;
  logic                   skidValid;
  logic                   inFire;
  logic                   outFire;

  assign mainValid = state_q[0];
  assign skidValid = state_q[1];

  // in_ready is a plain flop output; it never looks at out_ready.
  assign in_ready  = ~skidValid;
  assign out_valid = mainValid;
  assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

  assign inFire  = in_valid & in_ready;
  assign outFire = mainValid & out_ready;

  // With ZERO_BUBBLE=1 an empty stage shows a NOP (all zeros).
  assign out_data = (mainValid || !ZERO_BUBBLE) ? mainData_q : '0;

  // Single state machine. Flush wins over every handshake event, so a beat
  // offered in the flush cycle is dropped even if in_ready was high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      mainData_q <= '0;
      skidData_q <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      if (ZERO_BUBBLE) begin
        mainData_q <= '0;
        skidData_q <= '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (inFire) begin
            state_q    <= ONE;
            mainData_q <= in_data;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            mainData_q <= in_data;
          end else if (inFire) begin
            state_q    <= FULL;
            skidData_q <= in_data;
          end else if (outFire) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (outFire) begin
            state_q    <= ONE;
            mainData_q <= skidData_q;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  // Stall and bubble counters. They observe the handshake only and hold at
  // all-ones instead of wrapping. Flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (mainValid && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (!mainValid && out_ready && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// Testbench for pipe_stage_skid. Two instances share all inputs: dutZ uses
// ZERO_BUBBLE=1 and dutH uses ZERO_BUBBLE=0. The reference model is a FIFO
// queue of at most two beats. Directed scenarios come first, then a random
// run in which upstream holds its beat while it is not accepted.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int W = 76;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         inReadyZ, outValidZ, inReadyH, outValidH;
  logic [W-1:0] outDataZ, outDataH;
  logic [1:0]   occZ, occH;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0]  stallZ, bubbleZ, stallH, bubbleH;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] heldData;
  logic         lastAccepted;
  longint       mStall;
  longint       mBubble;

  pipe_stage_skid #(.PAYLOAD_W(W), .ZERO_BUBBLE(1'b1)) dutZ (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(inReadyZ), .in_data(in_data),
    .out_valid(outValidZ), .out_ready(out_ready), .out_data(outDataZ),
    .occupancy(occZ)
`ifdef PIPE_STAGE_SKID_PERF_EN
    , .perf_stall_cnt(stallZ), .perf_bubble_cnt(bubbleZ)
`endif
  );

  pipe_stage_skid #(.PAYLOAD_W(W), .ZERO_BUBBLE(1'b0)) dutH (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(inReadyH), .in_data(in_data),
    .out_valid(outValidH), .out_ready(out_ready), .out_data(outDataH),
    .occupancy(occH)
`ifdef PIPE_STAGE_SKID_PERF_EN
    , .perf_stall_cnt(stallH), .perf_bubble_cnt(bubbleH)
`endif
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every comparison funnels through here
  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model reaction to one rising edge, using the inputs seen at that edge
  task automatic modelEdge();
    bit ov;
    bit ir;
    ov = (mq.size() > 0);
    ir = (mq.size() < 2);
    lastAccepted = in_valid && ir;
    if (ov && !out_ready) mStall++;
    if (!ov && out_ready) mBubble++;
    if (flush) begin
      mq.delete();
    end else begin
      if (ov && out_ready) void'(mq.pop_front());
      if (in_valid && ir) mq.push_back(in_data);
    end
    if (mq.size() > 0) heldData = mq[0];
  endtask

  task automatic modelReset();
    mq.delete();
    heldData = '0;
    mStall   = 0;
    mBubble  = 0;
  endtask

  // Compare both instances with the queue model
  task automatic checkModel();
    logic [W-1:0] expZ;
    logic [W-1:0] expH;
    expZ = (mq.size() > 0) ? mq[0] : '0;
    expH = (mq.size() > 0) ? mq[0] : heldData;
    checkOutput("out_valid", outValidZ, (mq.size() > 0));
    checkOutput("out_data", outDataZ, expZ);
    checkOutput("in_ready", inReadyZ, (mq.size() < 2));
    checkOutput("occupancy", occZ, mq.size());
    checkOutput("hold.out_valid", outValidH, (mq.size() > 0));
    checkOutput("hold.out_data", outDataH, expH);
    checkOutput("hold.in_ready", inReadyH, (mq.size() < 2));
    checkOutput("hold.occupancy", occH, mq.size());
`ifdef PIPE_STAGE_SKID_PERF_EN
    checkOutput("perf_stall", stallZ, mStall);
    checkOutput("perf_bubble", bubbleZ, mBubble);
    checkOutput("hold.perf_stall", stallH, mStall);
    checkOutput("hold.perf_bubble", bubbleH, mBubble);
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at negedge
  task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                               input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkModel();
  endtask

  // Asynchronous reset in mid-cycle with in_valid held high
  task automatic doReset();
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = W'(1);
    out_ready = 1'b1;
    flush     = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst.out_valid", outValidZ, 1'b0);
    checkOutput("rst.out_data", outDataZ, 0);
    checkOutput("rst.in_ready", inReadyZ, 1'b1);
    checkOutput("rst.occupancy", occZ, 0);
    checkOutput("rst.hold.out_data", outDataH, 0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [95:0] rnd;
    logic        v;
    logic [W-1:0] d;

    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    modelReset();
    lastAccepted = 1'b0;
    v = 1'b0;
    d = '0;

    // Reset, then the held beat 0x1 is taken on the first free edge
    doReset();
    applyStimulus(1'b1, W'(1), 1'b1, 1'b0);
    checkOutput("first.out_valid", outValidZ, 1'b1);
    checkOutput("first.out_data", outDataZ, 1);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, W'(8'hA0 + i), 1'b1, 1'b0);
      checkOutput("stream.out_data", outDataZ, 8'hA0 + i);
      checkOutput("stream.in_ready", inReadyZ, 1'b1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Fill the skid buffer while stalled, then drain in order
    applyStimulus(1'b1, W'(8'hB0), 1'b0, 1'b0);
    applyStimulus(1'b1, W'(8'hB1), 1'b0, 1'b0);
    checkOutput("fill.occupancy", occZ, 2);
    checkOutput("fill.in_ready", inReadyZ, 1'b0);
    applyStimulus(1'b1, W'(8'hB2), 1'b0, 1'b0);
    checkOutput("fill.head", outDataZ, 8'hB0);
    applyStimulus(1'b1, W'(8'hB2), 1'b1, 1'b0);
    checkOutput("drain.b1", outDataZ, 8'hB1);
    applyStimulus(1'b1, W'(8'hB2), 1'b1, 1'b0);
    checkOutput("drain.b2", outDataZ, 8'hB2);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Flush a full stage while a new beat is offered
    applyStimulus(1'b1, W'(8'hC0), 1'b0, 1'b0);
    applyStimulus(1'b1, W'(8'hC1), 1'b0, 1'b0);
    applyStimulus(1'b1, W'(8'hC5), 1'b0, 1'b1);
    checkOutput("flush.occupancy", occZ, 0);
    checkOutput("flush.out_valid", outValidZ, 1'b0);
    checkOutput("flush.out_data", outDataZ, 0);
    checkOutput("flush.in_ready", inReadyZ, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Stale data held on the ZERO_BUBBLE=0 instance
    applyStimulus(1'b1, W'(8'hD3), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("hold.valid_low", outValidH, 1'b0);
    checkOutput("hold.stale_data", outDataH, 8'hD3);
    checkOutput("zero.bubble_data", outDataZ, 0);

`ifdef PIPE_STAGE_SKID_PERF_EN
    // Five stall cycles, then a flush that must not disturb the count
    doReset();
    applyStimulus(1'b1, W'(8'hE0), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("perf.stall5", stallZ, 5);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("perf.stall_after_flush", stallZ, 5);
`endif

    // Random traffic; upstream keeps an unaccepted beat stable
    lastAccepted = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!(v && !lastAccepted)) begin
        rnd = {$urandom(), $urandom(), $urandom()};
        d   = rnd[W-1:0];
        v   = ($urandom_range(3) != 0);
      end
      if (n == 200) begin
        doReset();
        v = 1'b0;
      end
      applyStimulus(v, d, ($urandom_range(2) != 0), ($urandom_range(15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
